uart_line_buffer: RTL and testbench

UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_line_mem.sv | 31 +++
 rtl/uart_line_buffer.sv | 114 +++++++++++
 tb/tb_uart_line_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-buffer types and default constants
package uart_pkg;

    // FILL collects bytes from the receiver, DRAIN replays them to the transmitter
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } line_state_e;

    localparam int         LINE_DEPTH_DEFAULT = 16;
    localparam logic [7:0] LINE_TERM_DEFAULT  = 8'h0A;

endpackage

// File: rtl/uart_line_mem.sv
// rtl/uart_line_mem.sv - DEPTH x 8 line storage, one write port, one asynchronous read port
module uart_line_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    // Next array contents: hold everything, overwrite the addressed entry on a write
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage is deliberately left unreset; stale bytes are never presented
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_line_buffer.sv
// rtl/uart_line_buffer.sv - collects one terminated line, then drains it in arrival order
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int         DEPTH = LINE_DEPTH_DEFAULT,
    parameter logic [7:0] TERM  = LINE_TERM_DEFAULT
) (
    input  logic                   clk,
    input  logic                   RsTx,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              LW         = AW + 1;
    localparam logic [LW-1:0]   LEVEL_LAST = LW'(DEPTH - 1);
    localparam logic [LW-1:0]   LEVEL_ONE  = LW'(1);

    line_state_e   state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0] level_q,    level_d;
    logic          overflow_q, overflow_d;
    logic          run_q,      run_d;

    logic          mem_we;
    logic [7:0]    mem_rdata;

    uart_line_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // run_q keeps in_ready low while in reset and for no longer than one edge after release
    assign in_ready  = run_q && (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? mem_rdata : 8'h00;
    assign level     = level_q;
    assign overflow  = overflow_q;

    // Next-state logic: fill until TERM or full, then drain until empty
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = 1'b0;
        run_d      = 1'b1;
        mem_we     = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid && in_ready) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    level_d  = level_q + LW'(1);
                    if (in_data == TERM) begin
                        state_d = DRAIN;
                    end else if (level_q == LEVEL_LAST) begin
                        // Line filled the buffer without a terminator: release it and flag
                        state_d    = DRAIN;
                        overflow_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    level_d  = level_q - LW'(1);
                    if (level_q == LEVEL_ONE) begin
                        // Every line starts at slot 0, so pointers never wrap mid-line
                        state_d  = FILL;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge RsTx) begin
        if (!RsTx) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: tb/tb_uart_line_buffer.sv
// tb/tb_uart_line_buffer.sv - scoreboard bench for uart_line_buffer
module tb_uart_line_buffer;

    logic       clk;
    logic       RsTx;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    uart_line_buffer #(
        .DEPTH (16),
        .TERM  (8'h0A)
    ) dut (
        .clk       (clk),
        .RsTx      (RsTx),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops and compares the next expected byte
    always @(negedge clk) begin
        if (RsTx && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_byte: got 0x%0h expected none (queue empty) at %0t", out_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL out_byte: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
                end
            end
        end
    end

    // Wait for in_ready, present one byte for one edge; expected output is queued
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            exp_q.push_back(b);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_level", 32'(level), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] hello [14];
        logic [7:0] line8 [8];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                  8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        line8 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0A};

        RsTx = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 RsTx = 1'b1;
        check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        // Hello line: nothing presented until the terminator is accepted
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send_byte(hello[i]);
            check("hello_out_valid", 32'(out_valid), (i == 13) ? 32'd1 : 32'd0);
        end
        wait_drained();

        // Single terminator: latency one cycle
        out_ready = 1'b0;
        send_byte(8'h0A);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'h0A);
        check("single_level", 32'(level), 32'd1);
        wait_drained();

        // Full buffer without terminator raises overflow for one cycle
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h41 + i));
            if (i == 14) check("ovf_before_full", 32'(overflow), 32'd0);
        end
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        check("ovf_level", 32'(level), 32'd16);
        // Stall with in_valid noise: output and level frozen, noise not stored
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            @(posedge clk); #1;
            if (c == 0) check("ovf_pulse_end", 32'(overflow), 32'd0);
            check("stall_out_data", 32'(out_data), 32'h41);
            check("stall_level", 32'(level), 32'd16);
        end
        in_valid = 1'b0;
        wait_drained();

        // Terminator in the last slot does not flag overflow
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte((i == 15) ? 8'h0A : 8'(8'h61 + i));
        end
        check("term_last_no_ovf", 32'(overflow), 32'd0);
        check("term_last_level", 32'(level), 32'd16);
        wait_drained();

        // Reset three bytes into an eight-byte drain
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(line8[i]);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        check("mid_level", 32'(level), 32'd5);
        RsTx = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        RsTx = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h0A);
        wait_drained();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
